tc4_gf2_mul_sched: RTL and testbench

- Sequencer for an area-reduced binary-field (carry-less, GF(2)[x]) multiplier using the 4-way limb split.
- Holds one bit-serial shift-and-XOR partial-product unit and time-multiplexes it over all 16 limb pairs (ai, bj).
- Accumulates each limb-pair product into the full 2N-bit result at offset (i+j)*LW.
- Sits between an operand source and result consumer through valid/ready handshakes. It is the low-area counterpart of the fully parallel multiplier.

---
 rtl/tc4_gf2_mul_sched_if.sv | 23 ++
 rtl/tc4_gf2_mul_sched.sv | 156 +++++++++++++++
 tb/tb_tc4_gf2_mul_sched.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/tc4_gf2_mul_sched_if.sv
// Operand/result handshake bundle for the time-multiplexed GF(2)[x] multiplier.
// master = operand source + result consumer, slave = the multiplier.
interface tc4_gf2_mul_sched_if #(
    parameter int unsigned N = 521
);
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] c;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, c
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, c
    );
endinterface

// File: rtl/tc4_gf2_mul_sched.sv
// Area-reduced carry-less multiplier: one bit-serial partial-product unit
// time-shared over the 16 limb pairs of a 4-way split, XOR-accumulated in place.
module tc4_gf2_mul_sched #(
    parameter int unsigned N = 521
) (
    input  logic                    clk,
    input  logic                    rst,
    tc4_gf2_mul_sched_if.slave      bus,
    output logic                    busy,
    output logic [3:0]              pair_idx
);
    localparam int unsigned LW   = (N + 3) / 4;
    localparam int unsigned AW   = 4 * LW;
    localparam int unsigned CW   = $clog2(LW);
    localparam int unsigned PPW  = 2 * LW - 1;
    localparam int unsigned CWD  = 2 * N;
    localparam int unsigned AIW  = $clog2(AW);
    localparam int unsigned OFFW = $clog2(CWD);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ACC  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    a_q, a_d;
    logic [AW-1:0]    b_q, b_d;
    logic [PPW-1:0]   pp_q, pp_d;
    logic [CWD-1:0]   acc_q, acc_d;
    logic [CWD-1:0]   c_q, c_d;
    logic [CW-1:0]    k_q, k_d;
    logic [3:0]       p_q, p_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;

    logic [1:0]       li, lj;
    logic             a_bit;
    logic [LW-1:0]    b_limb;
    logic [PPW-1:0]   pp_term;
    logic [OFFW-1:0]  acc_off;
    logic [CWD-1:0]   acc_next;

    // Datapath: current a-limb bit, shifted b-limb, and the accumulator update.
    always_comb begin
        li       = p_q[3:2];
        lj       = p_q[1:0];
        a_bit    = a_q[AIW'(li) * AIW'(LW) + AIW'(k_q)];
        b_limb   = b_q[AIW'(lj) * AIW'(LW) +: LW];
        pp_term  = PPW'(b_limb) << k_q;
        acc_off  = OFFW'({1'b0, li} + {1'b0, lj}) * OFFW'(LW);
        acc_next = acc_q ^ (CWD'(pp_q) << acc_off);
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        pp_d        = pp_q;
        acc_d       = acc_q;
        c_d         = c_q;
        k_d         = k_q;
        p_d         = p_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    a_d        = AW'(bus.a);
                    b_d        = AW'(bus.b);
                    acc_d      = '0;
                    pp_d       = '0;
                    p_d        = '0;
                    k_d        = '0;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = MUL;
                end
            end
            MUL: begin
                if (a_bit) begin
                    pp_d = pp_q ^ pp_term;
                end
                if (k_q == CW'(LW - 1)) begin
                    k_d     = '0;
                    state_d = ACC;
                end else begin
                    k_d = k_q + CW'(1);
                end
            end
            ACC: begin
                acc_d = acc_next;
                pp_d  = '0;
                if (p_q == 4'd15) begin
                    c_d         = acc_next;
                    out_valid_d = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = DONE;
                end else begin
                    p_d     = p_q + 4'd1;
                    state_d = MUL;
                end
            end
            DONE: begin
                // c is left untouched after the handshake until the next result.
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            pp_q        <= '0;
            acc_q       <= '0;
            c_q         <= '0;
            k_q         <= '0;
            p_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            pp_q        <= pp_d;
            acc_q       <= acc_d;
            c_q         <= c_d;
            k_q         <= k_d;
            p_q         <= p_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.c         = c_q;
    assign busy          = busy_q;
    assign pair_idx      = p_q;

endmodule

// File: tb/tb_tc4_gf2_mul_sched.sv
// Directed and random checks of the time-multiplexed GF(2)[x] multiplier
// against hand-computed products and a plain shift-and-XOR reference.
module tb_tc4_gf2_mul_sched;
    localparam int unsigned N   = 521;
    localparam int unsigned W2  = 2 * N;
    localparam int unsigned LAT = 2112;

    logic       clk = 1'b0;
    logic       rst;
    logic       busy;
    logic [3:0] pair_idx;
    int         total = 0;
    int         bad   = 0;

    always #5 clk = ~clk;

    tc4_gf2_mul_sched_if #(.N(N)) bus ();

    tc4_gf2_mul_sched #(.N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .busy     (busy),
        .pair_idx (pair_idx)
    );

    task automatic chk(input string tag, input logic [W2-1:0] got, input logic [W2-1:0] exp);
        int fd;
        total++;
        if (got !== exp) begin
            bad++;
            fd = -1;
            for (int i = W2 - 1; i >= 0; i--) begin
                if (got[i] !== exp[i]) fd = i;
            end
            $display("FAIL %s got[127:0]=%0h exp[127:0]=%0h first_diff_bit=%0d",
                     tag, got[127:0], exp[127:0], fd);
        end
    endtask

    function automatic logic [W2-1:0] clmul(input logic [N-1:0] x, input logic [N-1:0] y);
        logic [W2-1:0] r;
        r = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (x[i]) r = r ^ (W2'(y) << i);
        end
        return r;
    endfunction

    function automatic logic [W2-1:0] bitw(input int n);
        logic [W2-1:0] r;
        r    = '0;
        r[n] = 1'b1;
        return r;
    endfunction

    function automatic logic [N-1:0] rand_op();
        logic [N-1:0] r;
        for (int i = 0; i < int'(N); i++) r[i] = 1'($urandom_range(0, 1));
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait for in_ready (bounded) and present one operand pair for one accepting edge.
    task automatic accept(input logic [N-1:0] ta, input logic [N-1:0] tb_, input string tag);
        int cnt;
        cnt = 0;
        while (!bus.in_ready && cnt < 100) begin
            step();
            cnt++;
        end
        chk({tag, "_in_ready"}, W2'(bus.in_ready), W2'(1));
        bus.a        = ta;
        bus.b        = tb_;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        bus.a        = ~ta;
        bus.b        = ~tb_;
    endtask

    task automatic run_op(input logic [N-1:0] ta, input logic [N-1:0] tb_,
                          input logic [W2-1:0] exp, input int stall, input bit rnd,
                          input string tag);
        int cnt;
        bit ir_bad, busy_bad, hold_bad;
        accept(ta, tb_, tag);
        cnt      = 0;
        ir_bad   = 1'b0;
        busy_bad = 1'b0;
        while (!bus.out_valid && cnt < int'(LAT) + 100) begin
            if (bus.in_ready) ir_bad = 1'b1;
            if (!busy) busy_bad = 1'b1;
            if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
            step();
            cnt++;
        end
        bus.out_ready = 1'b0;
        chk({tag, "_latency"}, W2'(cnt), W2'(LAT));
        chk({tag, "_c"}, bus.c, exp);
        chk({tag, "_c_msb"}, W2'(bus.c[W2-1]), W2'(0));
        chk({tag, "_busy_done"}, W2'(busy), W2'(0));
        chk({tag, "_in_ready_low"}, W2'(ir_bad), W2'(0));
        chk({tag, "_busy_high"}, W2'(busy_bad), W2'(0));
        hold_bad = 1'b0;
        for (int s = 0; s < stall; s++) begin
            step();
            if (bus.out_valid !== 1'b1 || bus.c !== exp || bus.in_ready !== 1'b0) hold_bad = 1'b1;
        end
        if (stall > 0) chk({tag, "_hold"}, W2'(hold_bad), W2'(0));
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk({tag, "_out_valid_drop"}, W2'(bus.out_valid), W2'(0));
        chk({tag, "_in_ready_back"}, W2'(bus.in_ready), W2'(1));
        chk({tag, "_c_kept"}, bus.c, exp);
    endtask

    initial begin
        logic [N-1:0]  ra, rb;
        logic [N-1:0]  ones;
        logic [W2-1:0] big;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;
        ones          = '1;
        repeat (3) step();
        rst = 1'b0;
        chk("rst_in_ready", W2'(bus.in_ready), W2'(1));
        chk("rst_out_valid", W2'(bus.out_valid), W2'(0));
        chk("rst_busy", W2'(busy), W2'(0));
        chk("rst_c", bus.c, W2'(0));
        chk("rst_pair_idx", W2'(pair_idx), W2'(0));

        // Operands wiggling without in_valid must not start anything.
        bus.a = N'(12345);
        bus.b = N'(777);
        repeat (4) step();
        chk("idle_no_start", W2'(busy), W2'(0));

        run_op(N'(1), N'(1), W2'(1), 0, 1'b0, "one_x_one");
        run_op(N'(3), N'(3), W2'(5), 50, 1'b0, "sq_x1");
        big = bitw(520);
        run_op(N'(big), N'(big), bitw(1040), 0, 1'b0, "top_limbs");
        big = bitw(131);
        ra  = N'(big);
        big = bitw(392);
        rb  = N'(big);
        run_op(ra, rb, bitw(523), 0, 1'b0, "cross_limb");
        run_op(N'(0), ones, W2'(0), 2, 1'b0, "zero_x_ones");
        run_op(ones, N'(3), clmul(ones, N'(3)), 0, 1'b0, "ones_x3");

        // Produce a nonzero c first so the reset clear is observable.
        run_op(N'(6), N'(3), W2'(10), 0, 1'b0, "pre_reset");
        accept(N'(9), N'(11), "mid_reset");
        repeat (700) step();
        chk("mid_reset_pair", W2'(pair_idx), W2'(5));
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_reset_out_valid", W2'(bus.out_valid), W2'(0));
        chk("mid_reset_c", bus.c, W2'(0));
        chk("mid_reset_in_ready", W2'(bus.in_ready), W2'(1));
        chk("mid_reset_busy", W2'(busy), W2'(0));
        chk("mid_reset_pair_clr", W2'(pair_idx), W2'(0));
        run_op(N'(5), N'(7), W2'(27), 0, 1'b0, "after_reset");

        for (int t = 0; t < 16; t++) begin
            ra = rand_op();
            rb = rand_op();
            repeat ($urandom_range(0, 3)) begin
                bus.a = rand_op();
                step();
            end
            run_op(ra, rb, clmul(ra, rb), int'($urandom_range(0, 4)), 1'b1,
                   $sformatf("rand%0d", t));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
